// File: rtl/sdmac_reg_access_if.sv
// Host-side register bus of the SDMAC: asynchronous strobes and offset in,
// registered enables, command pulses and DSACK termination out.
interface sdmac_reg_access_if;
    logic       as_n;
    logic       ds_n;
    logic       cs_n;
    logic       r_w;
    logic [3:0] addr;
    logic       cntr_ena_n;
    logic       wtc_sel;
    logic       istr_rd;
    logic       st_dma;
    logic       flush;
    logic       clr_int;
    logic       sp_dma;
    logic [1:0] dsack_n;
    logic       busy;

    modport slave (
        input  as_n, ds_n, cs_n, r_w, addr,
        output cntr_ena_n, wtc_sel, istr_rd, st_dma, flush, clr_int, sp_dma, dsack_n, busy
    );

    modport master (
        output as_n, ds_n, cs_n, r_w, addr,
        input  cntr_ena_n, wtc_sel, istr_rd, st_dma, flush, clr_int, sp_dma, dsack_n, busy
    );
endinterface

// File: rtl/sdmac_reg_access.sv
// SDMAC register bus-cycle controller: strobe synchroniser, offset decode, enables,
// command pulses and 32-bit DSACK. Define REG_WAIT_STATE_EN to insert one wait cycle.
module sdmac_reg_access #(
    parameter int SYNC_STAGES = 2
) (
    input logic               sclk,
    input logic               rst_n,
    sdmac_reg_access_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_t;

    // Offsets of the command strobes: index 0 st_dma, 1 flush, 2 clr_int, 3 sp_dma.
    localparam logic [15:0] STROBE_ADDRS = 16'hF654;

    logic [SYNC_STAGES-1:0] as_sync_reg;
    logic [SYNC_STAGES-1:0] ds_sync_reg;
    logic [SYNC_STAGES-1:0] cs_sync_reg;
    logic [SYNC_STAGES-1:0] sync_valid_reg;
    logic                   as_s;
    logic                   ds_s;
    logic                   cs_s;
    logic                   armed_reg;
    state_t                 state_reg;
    state_t                 state_next;
    logic [3:0]             addr_reg;
    logic                   rw_reg;
    logic                   start;
    logic                   acking;
    logic                   enter_ack;
    logic [1:0]             dsack_n_reg;
    logic                   cntr_ena_n_reg;
    logic                   wtc_sel_reg;
    logic                   istr_rd_reg;
    logic                   busy_reg;
    logic [3:0]             strobe_reg;

    assign as_s = as_sync_reg[SYNC_STAGES-1];
    assign ds_s = ds_sync_reg[SYNC_STAGES-1];
    assign cs_s = cs_sync_reg[SYNC_STAGES-1];

    // sync_valid_reg marks when the chains hold real samples, so the reset-time ones
    // in the synchroniser cannot arm a cycle while _AS is still held low.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            as_sync_reg    <= '1;
            ds_sync_reg    <= '1;
            cs_sync_reg    <= '1;
            sync_valid_reg <= '0;
        end else begin
            as_sync_reg    <= {as_sync_reg[SYNC_STAGES-2:0], bus.as_n};
            ds_sync_reg    <= {ds_sync_reg[SYNC_STAGES-2:0], bus.ds_n};
            cs_sync_reg    <= {cs_sync_reg[SYNC_STAGES-2:0], bus.cs_n};
            sync_valid_reg <= {sync_valid_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign start = (state_reg == IDLE) && !as_s && !cs_s && !ds_s && armed_reg;

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            armed_reg <= 1'b0;
        end else if (start) begin
            armed_reg <= 1'b0;
        end else if (as_s && sync_valid_reg[SYNC_STAGES-1]) begin
            armed_reg <= 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            addr_reg  <= 4'h0;
            rw_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                addr_reg <= bus.addr;
                rw_reg   <= bus.r_w;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = DECODE;
            end
            DECODE: begin
                if (as_s) begin
                    state_next = IDLE;
                end else begin
`ifdef REG_WAIT_STATE_EN
                    state_next = WAIT;
`else
                    state_next = ACK;
`endif
                end
            end
`ifdef REG_WAIT_STATE_EN
            WAIT: begin
                state_next = as_s ? IDLE : ACK;
            end
`endif
            ACK: begin
                if (as_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    assign acking    = (state_next == ACK);
    assign enter_ack = acking && (state_reg != ACK);

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            dsack_n_reg    <= 2'b11;
            cntr_ena_n_reg <= 1'b1;
            wtc_sel_reg    <= 1'b0;
            istr_rd_reg    <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            dsack_n_reg    <= acking ? 2'b00 : 2'b11;
            cntr_ena_n_reg <= !(acking && (addr_reg == 4'h2));
            wtc_sel_reg    <= acking && (addr_reg == 4'h1);
            istr_rd_reg    <= acking && (addr_reg == 4'h7) && rw_reg;
            busy_reg       <= (state_next != IDLE);
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_strobe
        always_ff @(posedge sclk) begin
            if (!rst_n) begin
                strobe_reg[gi] <= 1'b0;
            end else begin
                strobe_reg[gi] <= enter_ack && (addr_reg == STROBE_ADDRS[gi*4 +: 4]);
            end
        end
    end

    assign bus.dsack_n    = dsack_n_reg;
    assign bus.cntr_ena_n = cntr_ena_n_reg;
    assign bus.wtc_sel    = wtc_sel_reg;
    assign bus.istr_rd    = istr_rd_reg;
    assign bus.busy       = busy_reg;
    assign bus.st_dma     = strobe_reg[0];
    assign bus.flush      = strobe_reg[1];
    assign bus.clr_int    = strobe_reg[2];
    assign bus.sp_dma     = strobe_reg[3];
endmodule

// File: tb/tb_sdmac_reg_access.sv
// Self-checking bench for sdmac_reg_access: expected enable vectors are queued per bus
// cycle and compared against the first DSACK cycle the controller produces.
module tb_sdmac_reg_access;
    localparam int S = 2;
`ifdef REG_WAIT_STATE_EN
    localparam int WS = 1;
`else
    localparam int WS = 0;
`endif
    localparam int LAT = S + 2 + WS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sdmac_reg_access_if bus_if();

    sdmac_reg_access #(.SYNC_STAGES(S)) dut (
        .sclk  (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // en bits: 6 cntr_ena (active), 5 wtc_sel, 4 istr_rd, 3 st_dma, 2 flush, 1 clr_int, 0 sp_dma
    logic [6:0] exp_q[$];

    int         obs_lat;
    int         obs_rel;
    int         obs_ack_len;
    int         obs_strobe_cyc;
    int         obs_level_bad;
    int         obs_outside_bad;
    logic [6:0] obs_first_en;

    function automatic logic [6:0] sample_en();
        return {~bus_if.cntr_ena_n, bus_if.wtc_sel, bus_if.istr_rd,
                bus_if.st_dma, bus_if.flush, bus_if.clr_int, bus_if.sp_dma};
    endfunction

    function automatic logic [6:0] exp_en(input logic [3:0] a, input logic rd);
        logic [6:0] e;
        e = '0;
        case (a)
            4'h1: e[5] = 1'b1;
            4'h2: e[6] = 1'b1;
            4'h4: e[3] = 1'b1;
            4'h5: e[2] = 1'b1;
            4'h6: e[1] = 1'b1;
            4'h7: e[4] = rd;
            4'hF: e[0] = 1'b1;
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic drive_strobes(input logic level);
        bus_if.as_n = level;
        bus_if.ds_n = level;
        bus_if.cs_n = level;
    endtask

    // One full bus cycle: strobes low until DSACK, hold, then release and wait for idle.
    task automatic do_cycle(input logic [3:0] a, input logic rd, input int hold);
        logic [6:0] en;
        int k;
        obs_lat = 0; obs_rel = 0; obs_ack_len = 0; obs_strobe_cyc = 0;
        obs_level_bad = 0; obs_outside_bad = 0; obs_first_en = '0;
        @(negedge clk);
        bus_if.addr = a;
        bus_if.r_w  = rd;
        drive_strobes(1'b0);
        k = 0;
        while (obs_lat == 0 && k < 20) begin
            @(negedge clk); k++;
            en = sample_en();
            if (bus_if.dsack_n == 2'b00) begin
                obs_lat = k; obs_first_en = en; obs_ack_len = 1;
                if (|en[3:0]) obs_strobe_cyc++;
            end else if (en != 7'd0) begin
                obs_outside_bad++;
            end
        end
        for (int i = 0; i < hold && obs_lat != 0; i++) begin
            @(negedge clk);
            en = sample_en();
            if (bus_if.dsack_n == 2'b00) begin
                obs_ack_len++;
                if (|en[3:0]) obs_strobe_cyc++;
                if (en[6:4] != obs_first_en[6:4]) obs_level_bad++;
            end else begin
                obs_outside_bad++;
            end
        end
        drive_strobes(1'b1);
        k = 0;
        while (obs_rel == 0 && k < 20) begin
            @(negedge clk); k++;
            en = sample_en();
            if (bus_if.dsack_n == 2'b11) begin
                obs_rel = k;
                if (en != 7'd0) obs_outside_bad++;
            end else begin
                obs_ack_len++;
                if (|en[3:0]) obs_strobe_cyc++;
                if (en[6:4] != obs_first_en[6:4]) obs_level_bad++;
            end
        end
        $display("cycle addr=%h rw=%b lat=%0d rel=%0d ack_len=%0d en=%b strobe_cyc=%0d",
                 a, rd, obs_lat, obs_rel, obs_ack_len, obs_first_en, obs_strobe_cyc);
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        bus_if.addr = 4'h2;
        bus_if.r_w  = 1'b0;
        drive_strobes(1'b0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        vectors++; if (bus_if.dsack_n !== 2'b11) begin miscompares++; $display("FAIL reset_dsack got %b want 11", bus_if.dsack_n); end
        vectors++; if (bus_if.cntr_ena_n !== 1'b1) begin miscompares++; $display("FAIL reset_cntr_ena got %b want 1", bus_if.cntr_ena_n); end
        vectors++; if (bus_if.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus_if.busy); end
        vectors++; if (sample_en() !== 7'd0) begin miscompares++; $display("FAIL reset_enables got %b want 0000000", sample_en()); end
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.busy !== 1'b0 || bus_if.dsack_n !== 2'b11) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL reset_unarmed active cycles got %0d want 0", bad); end
        drive_strobes(1'b1);
        repeat (S + 2) @(negedge clk);
    endtask

    task automatic test_control_write();
        exp_q.push_back(exp_en(4'h2, 1'b0));
        do_cycle(4'h2, 1'b0, 3);
        vectors++; if (obs_lat != LAT) begin miscompares++; $display("FAIL ctrl_latency got %0d want %0d", obs_lat, LAT); end
        vectors++; if (obs_first_en !== exp_q[0]) begin miscompares++; $display("FAIL ctrl_enables got %b want %b", obs_first_en, exp_q[0]); end
        void'(exp_q.pop_front());
        vectors++; if (obs_level_bad != 0) begin miscompares++; $display("FAIL ctrl_hold cycles without cntr_ena got %0d want 0", obs_level_bad); end
        vectors++; if (obs_rel < S || obs_rel > S + 1) begin miscompares++; $display("FAIL ctrl_release got %0d edges want %0d..%0d", obs_rel, S, S + 1); end
        vectors++; if (obs_outside_bad != 0) begin miscompares++; $display("FAIL ctrl_outside_ack got %0d want 0", obs_outside_bad); end
    endtask

    task automatic test_st_dma();
        exp_q.push_back(exp_en(4'h4, 1'b1));
        do_cycle(4'h4, 1'b1, 4);
        vectors++; if (obs_first_en !== exp_q[0]) begin miscompares++; $display("FAIL st_dma_enables got %b want %b", obs_first_en, exp_q[0]); end
        void'(exp_q.pop_front());
        vectors++; if (obs_strobe_cyc != 1) begin miscompares++; $display("FAIL st_dma_pulse_width got %0d want 1", obs_strobe_cyc); end
        vectors++; if (obs_ack_len < 5) begin miscompares++; $display("FAIL st_dma_ack_len got %0d want >=5", obs_ack_len); end
        vectors++; if (obs_lat != LAT) begin miscompares++; $display("FAIL st_dma_latency got %0d want %0d", obs_lat, LAT); end
    endtask

    task automatic test_unmapped();
        exp_q.push_back(exp_en(4'hA, 1'b0));
        do_cycle(4'hA, 1'b0, 2);
        vectors++; if (obs_lat != LAT) begin miscompares++; $display("FAIL unmapped_dsack latency got %0d want %0d", obs_lat, LAT); end
        vectors++; if (obs_first_en !== exp_q[0]) begin miscompares++; $display("FAIL unmapped_enables got %b want %b", obs_first_en, exp_q[0]); end
        void'(exp_q.pop_front());
        vectors++; if (obs_strobe_cyc != 0 || obs_outside_bad != 0) begin miscompares++; $display("FAIL unmapped_strobes got %0d/%0d want 0/0", obs_strobe_cyc, obs_outside_bad); end
    endtask

    task automatic test_register_map();
        logic [3:0] addrs [9] = '{4'h1, 4'h5, 4'h6, 4'h7, 4'h7, 4'hF, 4'h0, 4'h3, 4'hE};
        logic       rds   [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [6:0] e;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(exp_en(addrs[i], rds[i]));
            do_cycle(addrs[i], rds[i], 2);
            e = exp_q.pop_front();
            vectors++; if (obs_first_en !== e) begin miscompares++; $display("FAIL map_enables addr %h rw %b got %b want %b", addrs[i], rds[i], obs_first_en, e); end
            vectors++; if (obs_strobe_cyc != int'(|e[3:0])) begin miscompares++; $display("FAIL map_pulse addr %h got %0d want %0d", addrs[i], obs_strobe_cyc, int'(|e[3:0])); end
            vectors++; if (obs_level_bad != 0) begin miscompares++; $display("FAIL map_level_hold addr %h got %0d want 0", addrs[i], obs_level_bad); end
        end
    endtask

    // as_s low for a single edge: the controller enters DECODE and must fall back to IDLE.
    task automatic test_abort();
        int ack_cyc = 0;
        int en_cyc = 0;
        int busy_cyc = 0;
        @(negedge clk);
        bus_if.addr = 4'h4;
        bus_if.r_w  = 1'b0;
        drive_strobes(1'b0);
        @(negedge clk);
        drive_strobes(1'b1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus_if.dsack_n !== 2'b11) ack_cyc++;
            if (sample_en() != 7'd0) en_cyc++;
            if (bus_if.busy) busy_cyc++;
        end
        $display("abort addr=4 ack_cyc=%0d en_cyc=%0d busy_cyc=%0d", ack_cyc, en_cyc, busy_cyc);
        vectors++; if (ack_cyc != 0) begin miscompares++; $display("FAIL abort_dsack got %0d cycles want 0", ack_cyc); end
        vectors++; if (en_cyc != 0) begin miscompares++; $display("FAIL abort_strobes got %0d cycles want 0", en_cyc); end
        vectors++; if (busy_cyc != 1) begin miscompares++; $display("FAIL abort_busy got %0d cycles want 1", busy_cyc); end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        int sp_cyc = 0;
        int istr_cyc = 0;
        logic [1:0] prev = 2'b11;
        logic [6:0] e;
        logic [6:0] en;
        exp_q.push_back(exp_en(4'h7, 1'b1));
        exp_q.push_back(exp_en(4'hF, 1'b0));
        fork
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    en = sample_en();
                    if (prev == 2'b11 && bus_if.dsack_n == 2'b00) begin
                        acks++;
                        e = (exp_q.size() != 0) ? exp_q.pop_front() : 7'h7F;
                        vectors++; if (en !== e) begin miscompares++; $display("FAIL b2b_enables ack %0d got %b want %b", acks, en, e); end
                    end
                    if (bus_if.sp_dma) sp_cyc++;
                    if (bus_if.istr_rd) istr_cyc++;
                    prev = bus_if.dsack_n;
                end
            end
            begin
                int k = 0;
                @(negedge clk);
                bus_if.addr = 4'h7;
                bus_if.r_w  = 1'b1;
                drive_strobes(1'b0);
                while (bus_if.dsack_n != 2'b00 && k < 20) begin
                    @(negedge clk); k++;
                end
                repeat (2) @(negedge clk);
                drive_strobes(1'b1);
                @(negedge clk);
                bus_if.addr = 4'hF;
                bus_if.r_w  = 1'b0;
                drive_strobes(1'b0);
                repeat (S + 6 + WS) @(negedge clk);
                drive_strobes(1'b1);
            end
        join
        $display("back_to_back acks=%0d sp_cyc=%0d istr_cyc=%0d", acks, sp_cyc, istr_cyc);
        vectors++; if (acks != 2) begin miscompares++; $display("FAIL b2b_ack_count got %0d want 2", acks); end
        vectors++; if (sp_cyc != 1) begin miscompares++; $display("FAIL b2b_sp_dma_pulses got %0d want 1", sp_cyc); end
        vectors++; if (istr_cyc == 0) begin miscompares++; $display("FAIL b2b_istr_rd got %0d cycles want >0", istr_cyc); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_scoreboard leftover got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int bad = 0;
        @(negedge clk);
        bus_if.addr = 4'h2;
        bus_if.r_w  = 1'b0;
        drive_strobes(1'b0);
        while (bus_if.dsack_n != 2'b00 && k < 20) begin
            @(negedge clk); k++;
        end
        vectors++; if (k >= 20) begin miscompares++; $display("FAIL midreset_ack_timeout got %0d edges want <20", k); end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++; if (bus_if.dsack_n !== 2'b11 || bus_if.cntr_ena_n !== 1'b1 || bus_if.busy !== 1'b0) begin
            miscompares++; $display("FAIL midreset_outputs got dsack=%b cntr=%b busy=%b want 11/1/0", bus_if.dsack_n, bus_if.cntr_ena_n, bus_if.busy);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_if.busy !== 1'b0 || bus_if.dsack_n !== 2'b11) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL midreset_unarmed active cycles got %0d want 0", bad); end
        drive_strobes(1'b1);
        repeat (S + 2) @(negedge clk);
        exp_q.push_back(exp_en(4'h2, 1'b0));
        do_cycle(4'h2, 1'b0, 1);
        vectors++; if (obs_lat != LAT || obs_first_en !== exp_q[0]) begin
            miscompares++; $display("FAIL midreset_recovery got lat=%0d en=%b want lat=%0d en=%b", obs_lat, obs_first_en, LAT, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    initial begin
        bus_if.addr = 4'h0;
        bus_if.r_w  = 1'b1;
        drive_strobes(1'b1);
        test_reset();
        test_control_write();
        test_st_dma();
        test_unmapped();
        test_register_map();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached after %0d vectors", vectors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sdmac_reg_access.md
# sdmac_reg_access

Bus-cycle controller for the SDMAC register file, sitting directly upstream of the control register and the other DMA registers. It synchronises the host strobes (_AS, _DS, _CS) to SCLK and decodes the register offset. It then drives per-register enables, including the active-low write enable consumed by the control register, plus one-cycle command strobes and the 32-bit _DSACK termination. The handshake completes on _AS negation.

## Interface
- SYNC_STAGES, 2, synchroniser depth for _AS/_DS/_CS; legal values are 2 and 3.
- SCLK  in  1  system clock; all state changes on rising edge.
- _RST  in  1  reset, synchronous and active-low.
- _AS  in  1  host address strobe, asynchronous, active-low.
- _DS  in  1  host data strobe, asynchronous, active-low.
- _CS  in  1  SDMAC chip select, asynchronous, active-low.
- R_W  in  1  1 = read, 0 = write; sampled in DECODE.
- ADDR  in  4  register offset A[5:2]; sampled in DECODE.
- _CNTR_ENA  out  1  active-low control-register enable; low in ACK when offset = 4'h2.
- WTC_SEL  out  1  word-transfer-count select; high in ACK when offset = 4'h1.
- ISTR_RD  out  1  interrupt-status read select; high in ACK when offset = 4'h7 and read.
- ST_DMA, FLUSH, CLR_INT, SP_DMA  out  1 each  one-cycle command pulses for offsets 4'h4, 4'h5, 4'h6, 4'hF.
- _DSACK  out  2  termination, active-low; 2'b00 = 32-bit acknowledge, 2'b11 = idle.
- BUSY  out  1  high whenever the state is not IDLE.

## Operation
- Synchronised strobes are as_s, ds_s and cs_s, each SYNC_STAGES flops deep.
- Cycle start condition: as_s=0, cs_s=0, ds_s=0 and armed=1.
- armed is set on any edge with as_s=1 and cleared on entry to DECODE. Reset clears armed.
- States:
  - IDLE: all outputs inactive. Moves to DECODE on the start condition.
  - DECODE: latches ADDR and R_W. Moves to WAIT if REG_WAIT_STATE_EN is defined, otherwise to ACK.
  - WAIT: exactly one cycle, then moves to ACK.
  - ACK: _DSACK=2'b00 and the selected enable is asserted. Stays in ACK while as_s=0. Moves to IDLE on the first edge with as_s=1.
- Command strobes (ST_DMA, FLUSH, CLR_INT, SP_DMA) pulse high for exactly the first ACK cycle. They fire on both reads and writes; this is SDMAC strobe-register semantics.
- _CNTR_ENA stays low for the whole ACK state for both reads and writes. The control register qualifies the access with R_W and _DS.
- Unmapped offsets (4'h0, 4'h3, 4'h8–4'hE) still terminate with _DSACK=2'b00 but assert no enable or strobe.
- If as_s goes high during DECODE or WAIT (an aborted cycle), the next state is IDLE. No _DSACK and no strobe are issued.
- If cs_s goes high while in ACK, it is ignored; only as_s ends the cycle.
- Every output is registered directly from state and latched address; there are no combinational paths from inputs to outputs.

## Timing
- Reset values: state IDLE, armed=0, _DSACK=2'b11, _CNTR_ENA=1, all other outputs 0, synchroniser flops 1.
- Reset mid-cycle: on the first edge with _RST=0, everything returns to reset values. After _RST goes high, a still-low _AS starts nothing until it has been seen high (armed).
- Latency, with edge E0 being the first edge where the start condition holds:
  - DECODE is entered at E0.
  - _DSACK goes low and enables assert at E1, or at E2 with REG_WAIT_STATE_EN.
- From raw _AS/_DS falling to _DSACK low takes SYNC_STAGES+2 edges, plus 1 with REG_WAIT_STATE_EN.
- _DSACK returns to 2'b11 and enables drop on the edge where as_s=1 is first seen. That is SYNC_STAGES edges after raw _AS rises.
- Back-to-back cycles: a new start condition is honoured at the earliest on the edge after IDLE is re-entered, because armed must be set by as_s=1.

## Configuration
- REG_WAIT_STATE_EN defined: one WAIT cycle is inserted between DECODE and ACK, for slow register-read paths.
- REG_WAIT_STATE_EN undefined: DECODE goes straight to ACK and the WAIT state is not synthesised.

## Test plan
- Reset: hold _RST=0 for 2 edges with _AS=0 -> _DSACK=2'b11, _CNTR_ENA=1, BUSY=0. Release with _AS still 0 -> no cycle until _AS has toggled high.
- Control write: _CS=0, R_W=0, ADDR=4'h2, _AS/_DS low -> _CNTR_ENA=0 and _DSACK=2'b00 at edge SYNC_STAGES+2 (plus 1 with the macro). Raise _AS -> both inactive SYNC_STAGES edges later.
- ST_DMA read at ADDR=4'h4 -> ST_DMA high for exactly 1 cycle while _DSACK stays 2'b00 until _AS rises.
- Unmapped ADDR=4'hA write -> _DSACK=2'b00, no enable or strobe asserted.
- Abort: raise _AS one edge after DECODE -> return to IDLE, _DSACK never asserted, no strobes.
- ISTR read at 4'h7 followed immediately by SP_DMA write at 4'hF -> second cycle is acknowledged only after as_s has been seen high. SP_DMA pulses once.
